// File: rtl/acq_pkg.sv
// Shared types and command codes for the acquisition run/trigger sequencer.
// Optional prescaler feature is selected with the ACQ_PRESCALE_EN macro.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SAVE    = 3'd3,
        ST_HOLDOFF = 3'd4
    } acq_state_t;

    localparam logic [7:0] CMD_ARM       = 8'h01;
    localparam logic [7:0] CMD_STOP      = 8'h02;
    localparam logic [7:0] CMD_SOFT_TRIG = 8'h03;
    localparam logic [7:0] CMD_CLEAR     = 8'h04;

endpackage

// File: rtl/acq_occupancy_tracker.sv
// Shadow occupancy of the event FIFO, and a registered busy flag that is
// raised when the FIFO cannot take one more complete event.
module acq_occupancy_tracker
    import acq_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 1024,
    parameter  int EVENT_WORDS = 16,
    localparam int OCC_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             f125_clk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             full,
    output logic [OCC_W-1:0] occ,
    output logic             busy
);

    logic [OCC_W-1:0] occ_next;
    logic [OCC_W-1:0] free_next;

    // Writes beyond depth and reads from empty are dropped rather than wrapped.
    always_comb begin
        // NOTE: default assignment first so no path leaves occ_next unassigned (no latch).
        occ_next = occ;
        if (wr_en && !rd_en && (occ != OCC_W'(FIFO_DEPTH))) begin
            occ_next = occ + OCC_W'(1);
        end else if (rd_en && !wr_en && (occ != '0)) begin
            occ_next = occ - OCC_W'(1);
        end
        free_next = OCC_W'(FIFO_DEPTH) - occ_next;
    end

    always_ff @(posedge f125_clk) begin
        if (!aresetn) begin
            occ  <= '0;
            busy <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all registered state.
            occ  <= occ_next;
            busy <= full | (free_next < OCC_W'(EVENT_WORDS));
        end
    end

endmodule

// File: rtl/acq_controller.sv
// Run/trigger sequencer: command decode, trigger qualification, event FSM,
// hold-off/timeout timing and event counters. Optional prescaler: ACQ_PRESCALE_EN.
module acq_controller
    import acq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 1024,
    parameter int EVENT_WORDS = 16,
    parameter int HOLDOFF_CYC = 64,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 32
) (
    input  logic             f125_clk,
    input  logic             aresetn,
    input  logic [7:0]       cmd,
    input  logic             trigger_i,
    input  logic             event_ready_i,
    input  logic             event_saved_i,
    input  logic             fifo_wr_en_i,
    input  logic             fifo_rd_en_i,
    input  logic             full_i,
`ifdef ACQ_PRESCALE_EN
    input  logic [7:0]       prescale_i,
`endif
    output logic             trigger_o,
    output logic             armed_o,
    output logic             busy_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] event_count_o,
    output logic [15:0]      lost_count_o
);

    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_MAX = (HOLDOFF_CYC > TIMEOUT_CYC) ? HOLDOFF_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    acq_state_t       state, state_next;
    logic             run, run_next;
    logic [7:0]       cmd_q;
    logic             trig_q;
    logic             fire, fire_q;
    logic [TMR_W-1:0] tmr;
    logic [1:0]       lost_inc;
    logic             evt_inc;
    logic [16:0]      lost_sum;
    logic             cmd_new, cmd_arm, cmd_stop, cmd_soft, cmd_clear;
    logic             trig_edge;
    logic             timeout, holdoff_done;
    // Occupancy is kept by the tracker for observability; only busy drives the FSM.
    logic [OCC_W-1:0] occ_unused;

`ifdef ACQ_PRESCALE_EN
    logic [7:0] psc;
    logic       psc_skip;
`endif

    acq_occupancy_tracker #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .EVENT_WORDS(EVENT_WORDS)
    ) u_occ (
        .f125_clk(f125_clk),
        .aresetn (aresetn),
        .wr_en   (fifo_wr_en_i),
        .rd_en   (fifo_rd_en_i),
        .full    (full_i),
        .occ     (occ_unused),
        .busy    (busy_o)
    );

    // A command acts only on the cycle its code differs from the last sampled one.
    assign cmd_new   = (cmd != cmd_q);
    assign cmd_arm   = cmd_new && (cmd == CMD_ARM);
    assign cmd_stop  = cmd_new && (cmd == CMD_STOP);
    assign cmd_soft  = cmd_new && (cmd == CMD_SOFT_TRIG);
    assign cmd_clear = cmd_new && (cmd == CMD_CLEAR);

    assign trig_edge    = (trigger_i && !trig_q) || cmd_soft;
    assign run_next     = cmd_arm ? 1'b1 : (cmd_stop ? 1'b0 : run);
    assign timeout      = (tmr == TMR_W'(TIMEOUT_CYC - 1));
    assign holdoff_done = (tmr == TMR_W'(HOLDOFF_CYC - 1));

    assign state_o = state;
    assign armed_o = (state == ST_ARMED);

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        evt_inc    = 1'b0;
        lost_inc   = 2'd0;
`ifdef ACQ_PRESCALE_EN
        psc_skip   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (run_next) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                // A stop in the same cycle as an edge wins; the edge is not counted.
                if (!run_next) begin
                    state_next = ST_IDLE;
                end else if (trig_edge) begin
                    if (busy_o) begin
                        lost_inc = 2'd1;
                    end else begin
`ifdef ACQ_PRESCALE_EN
                        if (psc == prescale_i) fire = 1'b1;
                        else                   psc_skip = 1'b1;
`else
                        fire = 1'b1;
`endif
                        if (fire) state_next = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                lost_inc = {1'b0, trig_edge};
                if (event_ready_i) begin
                    state_next = ST_SAVE;
                end else if (timeout) begin
                    state_next = ST_HOLDOFF;
                    lost_inc   = lost_inc + 2'd1;
                end
            end
            ST_SAVE: begin
                lost_inc = {1'b0, trig_edge};
                if (event_saved_i) begin
                    state_next = ST_HOLDOFF;
                    evt_inc    = 1'b1;
                end else if (timeout) begin
                    state_next = ST_HOLDOFF;
                    lost_inc   = lost_inc + 2'd1;
                end
            end
            ST_HOLDOFF: begin
                lost_inc = {1'b0, trig_edge};
                if (holdoff_done) state_next = run_next ? ST_ARMED : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign lost_sum = {1'b0, lost_count_o} + {15'd0, lost_inc};

    always_ff @(posedge f125_clk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            run           <= 1'b0;
            cmd_q         <= '0;
            trig_q        <= 1'b0;
            fire_q        <= 1'b0;
            trigger_o     <= 1'b0;
            tmr           <= '0;
            event_count_o <= '0;
            lost_count_o  <= '0;
        end else begin
            state     <= state_next;
            run       <= run_next;
            cmd_q     <= cmd;
            trig_q    <= trigger_i;
            // The FSM enters CAPTURE on the edge; the sampler sees the pulse one cycle later.
            fire_q    <= fire;
            trigger_o <= fire_q;

            // Timer restarts on every state change and idles outside CAPTURE/SAVE/HOLDOFF.
            if ((state_next != state) || (state_next == ST_IDLE) || (state_next == ST_ARMED)) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end

            if (cmd_clear) begin
                event_count_o <= '0;
                lost_count_o  <= '0;
            end else begin
                if (evt_inc && !(&event_count_o)) event_count_o <= event_count_o + CNT_W'(1);
                lost_count_o <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
            end
        end
    end

`ifdef ACQ_PRESCALE_EN
    always_ff @(posedge f125_clk) begin
        if (!aresetn) begin
            psc <= '0;
        end else if (cmd_arm || fire) begin
            psc <= '0;
        end else if (psc_skip) begin
            psc <= psc + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acq_controller.sv
// Self-checking bench for acq_controller: trigger pulses are scoreboarded by
// expected cycle; state, busy and counters are checked against fixed expectations.
module tb_acq_controller;
    import acq_pkg::*;

    localparam int HO = 64;
    localparam int TO = 4096;

    logic        f125_clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        trigger_i = 1'b0;
    logic        event_ready_i = 1'b0;
    logic        event_saved_i = 1'b0;
    logic        fifo_wr_en_i = 1'b0;
    logic        fifo_rd_en_i = 1'b0;
    logic        full_i = 1'b0;
`ifdef ACQ_PRESCALE_EN
    logic [7:0]  prescale_i = 8'd0;
`endif
    logic        trigger_o;
    logic        armed_o;
    logic        busy_o;
    logic [2:0]  state_o;
    logic [31:0] event_count_o;
    logic [15:0] lost_count_o;

    acq_controller #(
        .FIFO_DEPTH (1024),
        .EVENT_WORDS(16),
        .HOLDOFF_CYC(HO),
        .TIMEOUT_CYC(TO),
        .CNT_W      (32)
    ) dut (
        .f125_clk     (f125_clk),
        .aresetn      (aresetn),
        .cmd          (cmd),
        .trigger_i    (trigger_i),
        .event_ready_i(event_ready_i),
        .event_saved_i(event_saved_i),
        .fifo_wr_en_i (fifo_wr_en_i),
        .fifo_rd_en_i (fifo_rd_en_i),
        .full_i       (full_i),
`ifdef ACQ_PRESCALE_EN
        .prescale_i   (prescale_i),
`endif
        .trigger_o    (trigger_o),
        .armed_o      (armed_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .event_count_o(event_count_o),
        .lost_count_o (lost_count_o)
    );

    always #4 f125_clk = ~f125_clk;

    int cyc = 0;
    always @(posedge f125_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_cyc;
    logic trig_prev = 1'b0;
    int t;
    int s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge f125_clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state_o !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, {29'd0, state_o}, {29'd0, st});
    endtask

    // Every trigger_o pulse must match the next expected cycle and last one cycle.
    always @(posedge f125_clk) begin
        #1;
        if (trigger_o === 1'b1) begin
            if (trig_prev) begin
                check("trig_width", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                check("trig_unexpected", 32'd1, 32'd0);
            end else begin
                exp_cyc = exp_q.pop_front();
                check("trig_cycle", cyc, exp_cyc);
            end
        end
        trig_prev = trigger_o;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_armed", {31'd0, armed_o}, 32'd0);
        check("rst_trig", {31'd0, trigger_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_evt", event_count_o, 32'd0);
        check("rst_lost", {16'd0, lost_count_o}, 32'd0);
        aresetn = 1'b1;
        tick();

        // ARM
        cmd = CMD_ARM;
        tick();
        check("arm_state", {29'd0, state_o}, 32'd1);
        check("arm_armed", {31'd0, armed_o}, 32'd1);

        // Event 1 with one lost edge in CAPTURE and two in HOLDOFF
        trigger_i = 1'b1;
        t = cyc;
        exp_q.push_back(t + 2);
        tick();
        check("ev1_capture", {29'd0, state_o}, 32'd2);
        trigger_i = 1'b0;
        tick();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        event_ready_i = 1'b1;
        tick();
        check("ev1_save", {29'd0, state_o}, 32'd3);
        event_ready_i = 1'b0;
        event_saved_i = 1'b1;
        s = cyc;
        tick();
        event_saved_i = 1'b0;
        check("ev1_holdoff", {29'd0, state_o}, 32'd4);
        check("ev1_count", event_count_o, 32'd1);
        trigger_i = 1'b1; tick();
        trigger_i = 1'b0; tick();
        trigger_i = 1'b1; tick();
        trigger_i = 1'b0; tick();
        while (cyc < s + HO) tick();
        check("ho_last", {29'd0, state_o}, 32'd4);
        tick();
        check("ho_rearm", {29'd0, state_o}, 32'd1);
        check("lost_3", {16'd0, lost_count_o}, 32'd3);

        // CLEAR
        cmd = CMD_CLEAR;
        tick();
        check("clr_evt", event_count_o, 32'd0);
        check("clr_lost", {16'd0, lost_count_o}, 32'd0);
        cmd = 8'h00;
        tick();

        // Timeout waiting for event_ready_i
        trigger_i = 1'b1;
        t = cyc;
        exp_q.push_back(t + 2);
        tick();
        trigger_i = 1'b0;
        while (cyc < t + TO) tick();
        check("to_capture", {29'd0, state_o}, 32'd2);
        tick();
        check("to_holdoff", {29'd0, state_o}, 32'd4);
        check("to_lost", {16'd0, lost_count_o}, 32'd1);
        check("to_evt", event_count_o, 32'd0);
        wait_state("to_rearm", 3'd1, HO + 4);

        // Busy threshold: 1008 words leaves room, 1009 does not
        fifo_wr_en_i = 1'b1;
        for (int i = 0; i < 1009; i++) begin
            tick();
            if (i == 1007) check("busy_1008", {31'd0, busy_o}, 32'd0);
        end
        fifo_wr_en_i = 1'b0;
        check("busy_1009", {31'd0, busy_o}, 32'd1);
        trigger_i = 1'b1; tick();
        trigger_i = 1'b0; tick();
        tick();
        check("busy_stay_armed", {29'd0, state_o}, 32'd1);
        check("busy_lost", {16'd0, lost_count_o}, 32'd2);
        fifo_rd_en_i = 1'b1;
        tick();
        fifo_rd_en_i = 1'b0;
        check("busy_rd_clear", {31'd0, busy_o}, 32'd0);
        full_i = 1'b1;
        tick();
        check("busy_full", {31'd0, busy_o}, 32'd1);
        full_i = 1'b0;
        tick();
        check("busy_full_off", {31'd0, busy_o}, 32'd0);

        // SOFT_TRIG, STOP during SAVE: event completes, then IDLE
        cmd = CMD_SOFT_TRIG;
        exp_q.push_back(cyc + 2);
        tick();
        check("soft_capture", {29'd0, state_o}, 32'd2);
        cmd = 8'h00;
        tick();
        event_ready_i = 1'b1;
        tick();
        event_ready_i = 1'b0;
        check("stop_save", {29'd0, state_o}, 32'd3);
        cmd = CMD_STOP;
        tick();
        cmd = 8'h00;
        check("stop_still_save", {29'd0, state_o}, 32'd3);
        event_saved_i = 1'b1;
        tick();
        event_saved_i = 1'b0;
        check("stop_evt", event_count_o, 32'd1);
        wait_state("stop_idle", 3'd0, HO + 4);
        tick();
        tick();
        check("stop_stay_idle", {29'd0, state_o}, 32'd0);

        // Edges in IDLE are ignored
        trigger_i = 1'b1; tick();
        trigger_i = 1'b0; tick();
        check("idle_edge_lost", {16'd0, lost_count_o}, 32'd2);

        // CLEAR on the same cycle as event_saved_i
        cmd = CMD_ARM;
        tick();
        check("rearm2", {29'd0, state_o}, 32'd1);
        cmd = CMD_SOFT_TRIG;
        exp_q.push_back(cyc + 2);
        tick();
        cmd = 8'h00;
        tick();
        event_ready_i = 1'b1;
        tick();
        event_ready_i = 1'b0;
        event_saved_i = 1'b1;
        cmd = CMD_CLEAR;
        tick();
        event_saved_i = 1'b0;
        cmd = 8'h00;
        check("clr_win_evt", event_count_o, 32'd0);
        check("clr_win_state", {29'd0, state_o}, 32'd4);
        wait_state("clr_rearm", 3'd1, HO + 4);

        // STOP has priority over a same-cycle edge in ARMED
        cmd = CMD_STOP;
        trigger_i = 1'b1;
        tick();
        cmd = 8'h00;
        trigger_i = 1'b0;
        check("stop_prio_state", {29'd0, state_o}, 32'd0);
        check("stop_prio_lost", {16'd0, lost_count_o}, 32'd0);
        tick();
        tick();

        // Reset mid-CAPTURE: no pulse, everything back to zero
        cmd = CMD_ARM;
        tick();
        cmd = 8'h00;
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        check("mid_capture", {29'd0, state_o}, 32'd2);
        aresetn = 1'b0;
        tick();
        tick();
        check("mid_rst_state", {29'd0, state_o}, 32'd0);
        check("mid_rst_trig", {31'd0, trigger_o}, 32'd0);
        check("mid_rst_armed", {31'd0, armed_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_evt", event_count_o, 32'd0);
        aresetn = 1'b1;
        tick();

`ifdef ACQ_PRESCALE_EN
        // Prescale 3: every 4th non-busy edge triggers; skipped edges are not lost
        prescale_i = 8'd3;
        cmd = CMD_ARM;
        tick();
        cmd = 8'h00;
        for (int i = 0; i < 8; i++) begin
            trigger_i = 1'b1;
            if ((i % 4) == 3) exp_q.push_back(cyc + 2);
            tick();
            trigger_i = 1'b0;
            tick();
            if ((i % 4) == 3) begin
                event_ready_i = 1'b1;
                tick();
                event_ready_i = 1'b0;
                event_saved_i = 1'b1;
                tick();
                event_saved_i = 1'b0;
                wait_state("psc_rearm", 3'd1, HO + 4);
            end else begin
                check("psc_skip_armed", {29'd0, state_o}, 32'd1);
            end
        end
        check("psc_lost", {16'd0, lost_count_o}, 32'd0);
        check("psc_evt", event_count_o, 32'd2);
`endif

        repeat (4) tick();
        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
